// File: rtl/store_buffer_pkg.sv
// Shared widths, buffer sizing defaults and the buffered-store entry layout
// for the MEM-stage store buffer.
package store_buffer_pkg;

  localparam int LEN_ADR_MEM = 10;
  localparam int LEN_DATA    = 32;
  localparam int SB_DEPTH    = 4;
  localparam int SB_PTR_W    = 2;

  typedef struct packed {
    logic [LEN_ADR_MEM-1:0] adr;
    logic [LEN_DATA-1:0]    data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_sb_fwd_match.sv
// Load-forwarding address match: finds whether any valid buffered store hits
// the query address and, if several do, the index of the youngest one.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic [DEPTH-1:0][LEN_ADR_MEM-1:0] ent_adr,
  input  logic [DEPTH-1:0]                  ent_valid,
  input  logic [PTR_W-1:0]                  head,
  input  logic [LEN_ADR_MEM-1:0]            query_adr,
  output logic                              hit,
  output logic [PTR_W-1:0]                  hit_idx
);

  logic [DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = ent_valid[gi] && (ent_adr[gi] == query_adr);
    end
  endgenerate

  // Walk from oldest (head) to youngest so the last match found wins.
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head + PTR_W'(k)]) begin
        hit_idx = head + PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order write-back store buffer between EX/MEM and data memory: stores
// retire into a FIFO, drain on load-free cycles, and loads forward from it.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic                   ld_valid,
  input  logic [LEN_ADR_MEM-1:0] adr,
  input  logic [LEN_DATA-1:0]    wdata,
  output logic [LEN_DATA-1:0]    ld_data,
  output logic                   stall,
  output logic                   empty,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LEN_ADR_MEM-1:0] mem_adr,
  output logic [LEN_DATA-1:0]    mem_data,
  input  logic [LEN_DATA-1:0]    mem_out
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  sb_entry_t entry_q [DEPTH];
  sb_entry_t entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic full, push, pop;
  logic hit;
  logic [PTR_W-1:0] hit_idx;
  logic [DEPTH-1:0][LEN_ADR_MEM-1:0] ent_adr;
  logic [DEPTH-1:0] ent_valid;

  // An entry is live when its distance from head is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [PTR_W-1:0] age;
      assign age           = PTR_W'(gi) - head_q;
      assign ent_adr[gi]   = entry_q[gi].adr;
      assign ent_valid[gi] = {1'b0, age} < count_q;
    end
  endgenerate

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .ent_adr   (ent_adr),
    .ent_valid (ent_valid),
    .head      (head_q),
    .query_adr (adr),
    .hit       (hit),
    .hit_idx   (hit_idx)
  );

  // A full buffer refuses the store even if it drains this cycle; reset
  // suppresses both so nothing buffered reaches memory.
  assign full  = (count_q == FULL_CNT);
  assign stall = st_valid && full;
  assign empty = (count_q == '0);
  assign push  = st_valid && !full && !rst;
  assign pop   = (count_q != '0) && !ld_valid && !rst;

  always_comb begin
    entry_d = entry_q;
    if (push) begin
      entry_d[tail_q].adr  = adr;
      entry_d[tail_q].data = wdata;
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_comb begin
    mem_write = pop;
    mem_read  = ld_valid && !hit;
    mem_adr   = '0;
    mem_data  = '0;
    ld_data   = '0;
    if (pop) begin
      mem_adr  = entry_q[head_q].adr;
      mem_data = entry_q[head_q].data;
    end else if (mem_read) begin
      mem_adr = adr;
    end
    if (ld_valid) begin
      ld_data = hit ? entry_q[hit_idx].data : mem_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-back store buffer between the EX/MEM pipeline register and the data memory of the MIPS pipeline. Stores retire into a small in-order FIFO instead of writing memory in the MEM cycle. Entries drain to memory on cycles with no load. Loads are serviced the same cycle, either by forwarding the youngest matching buffered store or by a combinational memory read.

## Interface
Parameters:
- DEPTH, 4: number of buffered stores; power of two, ≥2.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store instruction in MEM stage this cycle.
- ld_valid  input  1  load instruction in MEM stage this cycle.
- adr  input  `LEN_ADR_MEM  word address of the load or store.
- wdata  input  `LEN_DATA  store data.
- ld_data  output  `LEN_DATA  load result, valid in the same cycle as ld_valid.
- stall  output  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers; the store is held.
- empty  output  1  buffer holds no entries.
- mem_read  output  1  to data memory read.
- mem_write  output  1  to data memory write.
- mem_adr  output  `LEN_ADR_MEM  to data memory address.
- mem_data  output  `LEN_DATA  to data memory write data.
- mem_out  input  `LEN_DATA  from data memory read data.

## Operation
- Storage: DEPTH entries of {adr, data}, head pointer, tail pointer, count (PTR_W+1 bits). Pointers wrap modulo DEPTH.
- Push: st_valid && count<DEPTH writes {adr, wdata} at tail, then tail+1.
- Full: when st_valid && count==DEPTH, stall=1 and nothing is pushed, even if a drain occurs that cycle. The store is accepted on a later cycle once count<DEPTH.
- Drain:
  - Condition: count>0 && !ld_valid.
  - Outputs: mem_write=1, mem_adr=head.adr, mem_data=head.data.
  - Effect: the entry is popped at the edge, then head+1.
- A load always blocks the drain that cycle.
- Push and pop in the same cycle leave count unchanged.
- Load forwarding:
  - Compare adr against all valid entries.
  - On any match, ld_data = data of the youngest match (the one nearest tail), and mem_read=0.
  - On a miss, mem_read=1, mem_adr=adr, ld_data=mem_out.
- Simultaneous st_valid && ld_valid is not produced by the pipeline. If it occurs:
  - The load is serviced first and does not see the same-cycle store.
  - The store is pushed per the push rule.
- Invariants:
  - mem_read and mem_write are never both 1.
  - When both are 0, mem_adr and mem_data are 0.
- ld_data is 0 when ld_valid=0.
- Reset:
  - head, tail and count clear to 0; entries are not cleared.
  - Outputs after reset: empty=1, stall=0, mem_write=0, mem_read=0, ld_data=0.
  - A reset mid-operation discards all buffered stores; nothing is written back.

## Timing
- Store latency: at least 1 cycle from acceptance until it appears on the memory port (earliest is the next cycle with no load).
- Back-to-back stores with no loads sustain one push and one pop per cycle, so count never grows.
- Load latency: 0 cycles, combinational from adr/ld_valid/entries/mem_out to ld_data.
- stall is combinational from st_valid and registered count; there is no path from mem_out to stall.
- mem_write is asserted for exactly one cycle per entry, with address and data stable for the whole cycle.
- Program order to memory is preserved: FIFO order, no coalescing.

## Structure
- Constants go in defs.v alongside `LEN_ADR_MEM/`LEN_DATA/`SIZE_MEM: add `SB_DEPTH and `SB_PTR_W as defaults for the parameters.
- One sub-module, sb_fwd_match, holds the combinational match logic:
  - Inputs: entry addresses, valid mask, head pointer, query adr.
  - Outputs: hit and the youngest-hit index.
- The top level holds the FIFO registers, pointers, drain/push control and output muxing.

## Test plan
- Reset, then store adr=5 data=0x11, no loads: next cycle mem_write=1 with mem_adr=5, mem_data=0x11; the cycle after, empty=1.
- Store adr=8 data=0xAA, then next cycle load adr=8: ld_data=0xAA, mem_read=0, mem_write=0; the drain happens the cycle after the load.
- Stores adr=3 data=1, then adr=3 data=2, while loads hold the drain off; then load adr=3: ld_data=2 (youngest wins). Memory later sees writes 1 then 2 in order.
- Load miss adr=9 with memory[9]=0x77: mem_read=1, mem_adr=9, ld_data=0x77, no pop that cycle.
- Fill with 4 stores under continuous loads, then assert a 5th store: stall=1 until a load-free cycle drains one entry; the 5th store is accepted on the following cycle and count returns to 4.
- Fill with 3 entries, assert rst for one cycle: empty=1, mem_write stays 0, and memory contents are unchanged.
